// File: rtl/cv32e40s_rf_scrubber.sv
// ============================================================================
// Module      : cv32e40s_rf_scrubber
// Description : Background ECC scrubber that borrows idle register-file read
//               port 1 to check every stored word (x0 excluded).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40s_rf_scrubber #(
    parameter logic RV32           = 1'b0,  // 1'b0: RV32I (32 regs), 1'b1: RV32E (16 regs)
    parameter int   SCRUB_INTERVAL = 16,
    parameter int   URGENT_LIMIT   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       port_busy_i,
    output logic       scrub_req_o,
    output logic [4:0] scrub_raddr_o,
    input  logic       ecc_err_i,
    input  logic [4:0] waddr_i,
    input  logic       we_i,
    output logic       scrub_err_o,
    output logic [4:0] scrub_err_addr_o,
    output logic       pass_done_o,
    output logic       urgent_o
);

    localparam int c_NUM_REGS = (RV32 == 1'b1) ? 16 : 32;
    localparam int c_IW       = $clog2(SCRUB_INTERVAL + 1);
    localparam int c_WW       = $clog2(URGENT_LIMIT + 1);

    localparam logic [c_IW-1:0] c_IVL_RELOAD = c_IW'(SCRUB_INTERVAL - 1);
    localparam logic [c_WW-1:0] c_WAIT_MAX   = c_WW'(URGENT_LIMIT);
    localparam logic [4:0]      c_LAST_ADDR  = 5'(c_NUM_REGS - 1);
    localparam logic [4:0]      c_FIRST_ADDR = 5'd1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_REQ  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [4:0]      r_addr;
    logic [c_IW-1:0] r_ivl;
    logic [c_WW-1:0] r_wait;
    logic            r_scrub_err;
    logic [4:0]      r_err_addr;
    logic            r_pass_done;

    logic            w_grant;
    logic            w_collide;
    logic            w_valid;
    logic            w_scrub_req;
    logic            w_urgent;

    assign w_grant   = (r_state == c_ST_REQ) && !port_busy_i && enable_i;
    // A same-cycle write to the scrubbed register makes the read stale.
    assign w_collide = we_i && (waddr_i == r_addr);
    assign w_valid   = w_grant && !w_collide;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (!enable_i) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: w_next_state = c_ST_WAIT;
                c_ST_WAIT: if (r_ivl == '0) w_next_state = c_ST_REQ;
                c_ST_REQ:  if (w_valid) w_next_state = c_ST_WAIT;
                default:   w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_scrub_req = (r_state == c_ST_REQ) && enable_i && !port_busy_i;
        w_urgent    = (r_state == c_ST_REQ) && (r_wait == c_WAIT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ivl <= c_IVL_RELOAD;
        end else if ((w_next_state == c_ST_WAIT) && (r_state != c_ST_WAIT)) begin
            r_ivl <= c_IVL_RELOAD;
        end else if ((r_state == c_ST_WAIT) && (r_ivl != '0)) begin
            r_ivl <= r_ivl - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if ((r_state == c_ST_REQ) && enable_i && !w_valid) begin
            if (r_wait != c_WAIT_MAX) begin
                r_wait <= r_wait + 1'b1;
            end
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= c_FIRST_ADDR;
            r_scrub_err <= 1'b0;
            r_err_addr  <= '0;
            r_pass_done <= 1'b0;
        end else begin
            r_scrub_err <= w_valid && ecc_err_i;
            r_pass_done <= w_valid && (r_addr == c_LAST_ADDR);
            if (w_valid && ecc_err_i) begin
                r_err_addr <= r_addr;
            end
            if (w_valid) begin
                r_addr <= (r_addr == c_LAST_ADDR) ? c_FIRST_ADDR : r_addr + 5'd1;
            end
        end
    end

    assign scrub_req_o      = w_scrub_req;
    assign scrub_raddr_o    = r_addr;
    assign scrub_err_o      = r_scrub_err;
    assign scrub_err_addr_o = r_err_addr;
    assign pass_done_o      = r_pass_done;
    assign urgent_o         = w_urgent;

endmodule

`default_nettype wire
